// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped serial transmitter on the core's data-memory
// write port. Bytes written to TXDATA are queued in a small FIFO and sent as
// 8N1 frames on txd; STATUS is readable combinationally.
// Build option: define UART_TX_PARITY_EN to add an even-parity bit after the
// eight data bits (frame grows from 10 to 11 bit times).
module mmio_uart_tx #(
  parameter logic [7:0] BASE_ADDR    = 8'hF0,
  parameter int         CLKS_PER_BIT = 4,
  parameter int         FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] dataadr,
  input  logic [7:0] writedata,
  input  logic       memwrite,
  output logic [7:0] readdata,
  output logic       sel,
  output logic       txd,
  output logic       busy
);

  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t            state_reg;
  logic              txd_reg;
  logic [7:0]        shift_reg;
  logic [2:0]        bit_cnt_reg;
  logic [BAUD_W-1:0] baud_cnt_reg;
`ifdef UART_TX_PARITY_EN
  logic              parity_reg;
`endif

  logic [7:0]        fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [CNT_W-1:0]  count_reg;
  logic              overflow_reg;

  logic              fifo_full;
  logic              fifo_empty;
  logic              baud_done;
  logic              pop;
  logic              wr_txdata;
  logic              wr_status;
  logic              push_ok;
  logic              push_rejected;
  logic [7:0]        status;

  // Address bits [1:0] select nothing: registers are word-wide slots.
  logic unused_addr_bits;
  assign unused_addr_bits = &{1'b0, dataadr[1:0]};

  assign sel        = (dataadr[7:3] == BASE_ADDR[7:3]);
  assign fifo_full  = (count_reg == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (count_reg == '0);
  assign baud_done  = (baud_cnt_reg == BAUD_W'(CLKS_PER_BIT - 1));
  assign busy       = (state_reg != S_IDLE);
  assign txd        = txd_reg;
  assign status     = {4'b0000, overflow_reg, busy, fifo_empty, fifo_full};

  // Pop/push decode: a pop frees a slot for a push landing in the same cycle.
  always_comb begin
    pop           = !fifo_empty &&
                    ((state_reg == S_IDLE) || ((state_reg == S_STOP) && baud_done));
    wr_txdata     = memwrite && sel && !dataadr[2];
    wr_status     = memwrite && sel && dataadr[2];
    push_ok       = wr_txdata && (!fifo_full || pop);
    push_rejected = wr_txdata && !push_ok;
  end

  // Register read mux; TXDATA reads as zero, anything outside the window is zero.
  always_comb begin
    readdata = 8'h00;
    if (sel && dataadr[2]) begin
      readdata = status;
    end
  end

  // FIFO storage: plain array without reset so it maps onto RAM.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_mem[wr_ptr_reg] <= writedata;
    end
  end

  // FIFO pointers, occupancy and the sticky overflow flag (set beats clear).
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= (wr_ptr_reg == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_reg <= (rd_ptr_reg == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_reg + PTR_W'(1);
      end
      case ({push_ok, pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
      if (push_rejected) begin
        overflow_reg <= 1'b1;
      end else if (wr_status && writedata[3]) begin
        overflow_reg <= 1'b0;
      end
    end
  end

  // Transmit FSM: start bit, 8 data bits LSB first, optional parity, stop bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= S_IDLE;
      txd_reg      <= 1'b1;
      shift_reg    <= 8'h00;
      bit_cnt_reg  <= 3'd0;
      baud_cnt_reg <= '0;
`ifdef UART_TX_PARITY_EN
      parity_reg   <= 1'b0;
`endif
    end else begin
      if (pop) begin
        shift_reg   <= fifo_mem[rd_ptr_reg];
        bit_cnt_reg <= 3'd0;
`ifdef UART_TX_PARITY_EN
        parity_reg  <= ^fifo_mem[rd_ptr_reg];
`endif
      end
      case (state_reg)
        S_IDLE: begin
          txd_reg <= 1'b1;
          if (pop) begin
            baud_cnt_reg <= '0;
            state_reg    <= S_START;
            txd_reg      <= 1'b0;
          end
        end
        S_START: begin
          if (baud_done) begin
            baud_cnt_reg <= '0;
            state_reg    <= S_DATA;
            txd_reg      <= shift_reg[0];
          end else begin
            baud_cnt_reg <= baud_cnt_reg + BAUD_W'(1);
          end
        end
        S_DATA: begin
          if (baud_done) begin
            baud_cnt_reg <= '0;
            if (bit_cnt_reg == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state_reg <= S_PARITY;
              txd_reg   <= parity_reg;
`else
              state_reg <= S_STOP;
              txd_reg   <= 1'b1;
`endif
            end else begin
              shift_reg   <= shift_reg >> 1;
              txd_reg     <= shift_reg[1];
              bit_cnt_reg <= bit_cnt_reg + 3'd1;
            end
          end else begin
            baud_cnt_reg <= baud_cnt_reg + BAUD_W'(1);
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (baud_done) begin
            baud_cnt_reg <= '0;
            state_reg    <= S_STOP;
            txd_reg      <= 1'b1;
          end else begin
            baud_cnt_reg <= baud_cnt_reg + BAUD_W'(1);
          end
        end
`endif
        S_STOP: begin
          if (baud_done) begin
            baud_cnt_reg <= '0;
            if (pop) begin
              state_reg <= S_START;
              txd_reg   <= 1'b0;
            end else begin
              state_reg <= S_IDLE;
              txd_reg   <= 1'b1;
            end
          end else begin
            baud_cnt_reg <= baud_cnt_reg + BAUD_W'(1);
          end
        end
        default: begin
          state_reg <= S_IDLE;
          txd_reg   <= 1'b1;
        end
      endcase
    end
  end

endmodule
